// File: rtl/alu_display_ctrl.sv
// alu_display_ctrl: operand/opcode controller for the ALU bring-up board.
// Loads ALU operands and opcode from touch-screen strobes, optionally steps
// the opcode on a timer, records recent ALU results in a circular history
// and maps all of it onto the LCD slots requested by lcd_module.
//
// Input handshake: input_valid is a one-cycle strobe with no back-pressure
// (there is no ready); input_sel and input_value are only meaningful in the
// cycle input_valid is high, and every strobe is acted on at that edge.
module alu_display_ctrl #(
  parameter int WIDTH      = 32,
  parameter int OP_W       = 3,
  parameter int HIST_DEPTH = 4,
  parameter int STEP_DIV   = 10_000_000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [1:0]       input_sel,
  input  logic             sw_cin,
  input  logic             sw_auto,
  input  logic             input_valid,
  input  logic [31:0]      input_value,
  input  logic [5:0]       display_number,
  output logic             display_valid,
  output logic [39:0]      display_name,
  output logic [31:0]      display_value,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [OP_W-1:0]  alu_op,
  output logic             alu_ci,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_co,
  output logic             led_cout,
  output logic             led_auto
);

  localparam int CNT_W = $clog2(STEP_DIV);
  localparam int PTR_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam int HCW   = $clog2(HIST_DEPTH + 1);

  // Switch synchronisers
  logic cin_meta, cin_sync;
  logic auto_meta, auto_sync;

  // Operand / opcode registers
  logic [WIDTH-1:0] in1_q, in2_q;
  logic [OP_W-1:0]  op_q;

  // Auto-step timer
  logic [CNT_W-1:0] step_cnt;
  logic             step_tick;

  // Touch-input decode
  logic ld_in1, ld_in2, ld_op, ld_clr;

  // Change detection: upd_evt marks an edge at which an operand, the opcode
  // or the carry-in changes; chg follows one cycle later so that alu_out has
  // settled on the new operands before it is captured.
  logic ci_toggle, upd_evt, chg_pend, chg;

  // Result history
  logic [WIDTH-1:0] hist [2**PTR_W];
  logic [PTR_W-1:0] ptr;
  logic [HCW-1:0]   hcnt;

  // Display path
  logic        disp_v_d;
  logic [39:0] disp_n_d;
  logic [31:0] disp_val_d;
  int          hist_k, hist_idx;

  assign ld_in1 = input_valid && (input_sel == 2'd0);
  assign ld_in2 = input_valid && (input_sel == 2'd1);
  assign ld_op  = input_valid && (input_sel == 2'd2);
  assign ld_clr = input_valid && (input_sel == 2'd3);

  assign step_tick = auto_sync && (step_cnt == CNT_W'(STEP_DIV - 1));
  assign ci_toggle = cin_meta != cin_sync;
  assign upd_evt   = ld_in1 | ld_in2 | ld_op | step_tick | ci_toggle;

  assign alu_in1  = in1_q;
  assign alu_in2  = in2_q;
  assign alu_op   = op_q;
  assign alu_ci   = cin_sync;
  assign led_auto = auto_sync;

  // Two-flop synchronisers for the asynchronous switches
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cin_meta  <= 1'b0;
      cin_sync  <= 1'b0;
      auto_meta <= 1'b0;
      auto_sync <= 1'b0;
    end else begin
      cin_meta  <= sw_cin;
      cin_sync  <= cin_meta;
      auto_meta <= sw_auto;
      auto_sync <= auto_meta;
    end
  end

  // Auto-step counter: free-runs while auto mode is on, parked at 0 otherwise
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step_cnt <= '0;
    end else if (!auto_sync || step_tick) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt + CNT_W'(1);
    end
  end

  // Operand and opcode registers; a manual opcode load overrides a step
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      in1_q <= '0;
      in2_q <= '0;
      op_q  <= '0;
    end else begin
      if (ld_in1) in1_q <= input_value[WIDTH-1:0];
      if (ld_in2) in2_q <= input_value[WIDTH-1:0];
      if (ld_op) begin
        op_q <= input_value[OP_W-1:0];
      end else if (step_tick) begin
        op_q <= op_q + OP_W'(1);
      end
    end
  end

  // Change pipeline and carry-out LED
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chg_pend <= 1'b0;
      chg      <= 1'b0;
      led_cout <= 1'b0;
    end else begin
      chg_pend <= upd_evt;
      chg      <= chg_pend;
      led_cout <= alu_co;
    end
  end

  // Circular history; a clear in the same cycle as a capture suppresses it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr  <= '0;
      hcnt <= '0;
      for (int i = 0; i < 2**PTR_W; i++) hist[i] <= '0;
    end else if (ld_clr) begin
      ptr  <= '0;
      hcnt <= '0;
    end else if (chg) begin
      hist[ptr] <= alu_out;
      ptr       <= (ptr == PTR_W'(HIST_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
      if (hcnt != HCW'(HIST_DEPTH)) hcnt <= hcnt + HCW'(1);
    end
  end

  // Slot decode: name/value/valid for the slot lcd_module is asking for
  always_comb begin
    disp_v_d   = 1'b0;
    disp_n_d   = '0;
    disp_val_d = '0;
    hist_k     = int'(display_number) - 9;
    hist_idx   = 0;
    case (display_number)
      6'd1: begin disp_v_d = 1'b1; disp_n_d = "Oper1"; disp_val_d = 32'(in1_q);    end
      6'd2: begin disp_v_d = 1'b1; disp_n_d = "Oper2"; disp_val_d = 32'(in2_q);    end
      6'd3: begin disp_v_d = 1'b1; disp_n_d = "OP   "; disp_val_d = 32'(op_q);     end
      6'd4: begin disp_v_d = 1'b1; disp_n_d = "CI   "; disp_val_d = 32'(cin_sync); end
      6'd5: begin disp_v_d = 1'b1; disp_n_d = "Out  "; disp_val_d = 32'(alu_out);  end
      6'd6: begin disp_v_d = 1'b1; disp_n_d = "CO   "; disp_val_d = 32'(alu_co);   end
      6'd7: begin disp_v_d = 1'b1; disp_n_d = "AUTO "; disp_val_d = 32'(auto_sync); end
      6'd8: begin disp_v_d = 1'b1; disp_n_d = "HCNT "; disp_val_d = 32'(hcnt);     end
      default: begin
        // HISTk is the k-th newest entry, i.e. k slots behind the write pointer
        if (hist_k >= 0 && hist_k < HIST_DEPTH && hist_k < int'(hcnt)) begin
          hist_idx = int'(ptr) + HIST_DEPTH - 1 - hist_k;
          if (hist_idx >= HIST_DEPTH) hist_idx = hist_idx - HIST_DEPTH;
          disp_v_d   = 1'b1;
          disp_n_d   = {"HIST", 8'(48 + hist_k)};
          disp_val_d = 32'(hist[PTR_W'(hist_idx)]);
        end
      end
    endcase
  end

  // Display outputs registered one cycle behind display_number
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      display_valid <= 1'b0;
      display_name  <= '0;
      display_value <= '0;
    end else begin
      display_valid <= disp_v_d;
      display_name  <= disp_n_d;
      display_value <= disp_val_d;
    end
  end

endmodule

// File: tb/tb_alu_display_ctrl.sv
// Bench for alu_display_ctrl with a stub adder ALU (in1+in2+ci+op), a
// reference model of operands and history, and a display scoreboard.
module tb_alu_display_ctrl;
  localparam int WIDTH    = 16;
  localparam int OP_W     = 3;
  localparam int HD       = 4;
  localparam int STEP_DIV = 4;
  localparam int SW       = WIDTH + 1;

  typedef struct packed {
    logic [5:0]  n;
    logic        v;
    logic [39:0] nm;
    logic [31:0] val;
  } disp_t;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] value;
    logic        h0_v;
    logic [31:0] h0;
    logic [31:0] hcnt;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic [1:0]  input_sel = '0;
  logic        sw_cin = 1'b0, sw_auto = 1'b0, input_valid = 1'b0;
  logic [31:0] input_value = '0;
  logic [5:0]  display_number = '0;
  logic        display_valid;
  logic [39:0] display_name;
  logic [31:0] display_value;
  logic [WIDTH-1:0] alu_in1, alu_in2, alu_out;
  logic [OP_W-1:0]  alu_op;
  logic        alu_ci, alu_co, led_cout, led_auto;
  logic [WIDTH:0] alu_sum;

  always #5 clk = ~clk;

  assign alu_sum = {1'b0, alu_in1} + {1'b0, alu_in2} + SW'(alu_ci) + SW'(alu_op);
  assign alu_out = alu_sum[WIDTH-1:0];
  assign alu_co  = alu_sum[WIDTH];

  alu_display_ctrl #(.WIDTH(WIDTH), .OP_W(OP_W), .HIST_DEPTH(HD), .STEP_DIV(STEP_DIV)) dut (
    .clk(clk), .resetn(resetn), .input_sel(input_sel), .sw_cin(sw_cin),
    .sw_auto(sw_auto), .input_valid(input_valid), .input_value(input_value),
    .display_number(display_number), .display_valid(display_valid),
    .display_name(display_name), .display_value(display_value),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_ci(alu_ci),
    .alu_out(alu_out), .alu_co(alu_co), .led_cout(led_cout), .led_auto(led_auto)
  );

  // ---------------- checking ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] m_in1 = '0, m_in2 = '0;
  logic [OP_W-1:0]  m_op = '0;
  logic             m_ci = 1'b0, m_auto = 1'b0;
  int               m_cnt = 0;
  logic [WIDTH-1:0] m_hist[$];

  function automatic logic [WIDTH:0] m_sum();
    return {1'b0, m_in1} + {1'b0, m_in2} + SW'(m_ci) + SW'(m_op);
  endfunction

  task automatic m_capture();
    logic [WIDTH:0] s;
    s = m_sum();
    m_hist.push_front(s[WIDTH-1:0]);
    if (m_hist.size() > HD) void'(m_hist.pop_back());
    if (m_cnt < HD) m_cnt++;
  endtask

  task automatic m_reset();
    m_in1 = '0; m_in2 = '0; m_op = '0; m_ci = 1'b0; m_auto = 1'b0;
    m_cnt = 0; m_hist.delete();
  endtask

  function automatic disp_t mk(input int n, input logic v, input logic [39:0] nm,
                               input logic [31:0] val);
    disp_t d;
    d.n = 6'(n); d.v = v; d.nm = nm; d.val = val;
    return d;
  endfunction

  function automatic logic [39:0] slot_name(input int n);
    case (n)
      1: return "Oper1";
      2: return "Oper2";
      3: return "OP   ";
      4: return "CI   ";
      5: return "Out  ";
      6: return "CO   ";
      7: return "AUTO ";
      8: return "HCNT ";
      default: return 40'd0;
    endcase
  endfunction

  function automatic disp_t exp_slot(input int n);
    logic [WIDTH:0] s;
    int k;
    s = m_sum();
    k = n - 9;
    case (n)
      1: return mk(n, 1'b1, slot_name(n), 32'(m_in1));
      2: return mk(n, 1'b1, slot_name(n), 32'(m_in2));
      3: return mk(n, 1'b1, slot_name(n), 32'(m_op));
      4: return mk(n, 1'b1, slot_name(n), 32'(m_ci));
      5: return mk(n, 1'b1, slot_name(n), 32'(s[WIDTH-1:0]));
      6: return mk(n, 1'b1, slot_name(n), 32'(s[WIDTH]));
      7: return mk(n, 1'b1, slot_name(n), 32'(m_auto));
      8: return mk(n, 1'b1, slot_name(n), 32'(m_cnt));
      default: begin
        if (k >= 0 && k < HD && k < m_cnt)
          return mk(n, 1'b1, {"HIST", 8'(48 + k)}, 32'(m_hist[k]));
        return mk(n, 1'b0, 40'd0, 32'd0);
      end
    endcase
  endfunction

  // ---------------- display scoreboard ----------------
  disp_t exp_q[$];
  disp_t mon_e;
  logic  req_v = 1'b0;
  logic  chk_v = 1'b0;

  always @(posedge clk) chk_v <= req_v;

  always @(negedge clk) begin
    if (chk_v) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_underflow: got no expected entry for slot %0d", display_number);
      end else begin
        mon_e = exp_q.pop_front();
        chk($sformatf("slot%0d_valid", mon_e.n), 64'(display_valid), 64'(mon_e.v));
        chk($sformatf("slot%0d_name", mon_e.n), 64'(display_name), 64'(mon_e.nm));
        chk($sformatf("slot%0d_value", mon_e.n), 64'(display_value), 64'(mon_e.val));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic show(input int n, input disp_t e);
    display_number = 6'(n);
    req_v = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_v = 1'b0;
  endtask

  task automatic show_m(input int n);
    show(n, exp_slot(n));
  endtask

  task automatic load(input logic [1:0] sel, input logic [31:0] val);
    input_sel = sel;
    input_value = val;
    input_valid = 1'b1;
    @(posedge clk); #1;
    input_valid = 1'b0;
    case (sel)
      2'd0: begin m_in1 = val[WIDTH-1:0]; m_capture(); end
      2'd1: begin m_in2 = val[WIDTH-1:0]; m_capture(); end
      2'd2: begin m_op = val[OP_W-1:0]; m_capture(); end
      default: begin m_hist.delete(); m_cnt = 0; end
    endcase
  endtask

  task automatic wait_op_change(input int limit, output int cycles);
    logic [OP_W-1:0] prev;
    prev = alu_op;
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (alu_op == prev && cycles < limit);
    if (alu_op == prev) begin
      tests++;
      fails++;
      $display("FAIL op_step_timeout: op stayed %0d for %0d cycles", alu_op, cycles);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in1"}, 64'(alu_in1), 64'd0);
    chk({tag, "_in2"}, 64'(alu_in2), 64'd0);
    chk({tag, "_op"}, 64'(alu_op), 64'd0);
    chk({tag, "_ci"}, 64'(alu_ci), 64'd0);
    chk({tag, "_led_cout"}, 64'(led_cout), 64'd0);
    chk({tag, "_led_auto"}, 64'(led_auto), 64'd0);
    chk({tag, "_disp_valid"}, 64'(display_valid), 64'd0);
    chk({tag, "_disp_name"}, 64'(display_name), 64'd0);
    chk({tag, "_disp_value"}, 64'(display_value), 64'd0);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    vec_t  tbl[10];
    disp_t rst_tbl[12];
    disp_t e_old;
    int    c;
    logic  prev_co;

    // Reset-poll table: slots 1..8 valid with zero values, history slots empty
    for (int i = 0; i < 12; i++)
      rst_tbl[i] = mk(i + 1, (i < 8), slot_name(i + 1), 32'd0);

    // Load table starting from In1=5, In2=7, op=0, two entries (12, 5)
    tbl[0] = '{2'd1, 32'd0, 1'b1, 32'd5, 32'd3};
    tbl[1] = '{2'd3, 32'd0, 1'b0, 32'd0, 32'd0};
    tbl[2] = '{2'd0, 32'd1, 1'b1, 32'd1, 32'd1};
    tbl[3] = '{2'd0, 32'd2, 1'b1, 32'd2, 32'd2};
    tbl[4] = '{2'd0, 32'd3, 1'b1, 32'd3, 32'd3};
    tbl[5] = '{2'd0, 32'd4, 1'b1, 32'd4, 32'd4};
    tbl[6] = '{2'd0, 32'd5, 1'b1, 32'd5, 32'd4};
    tbl[7] = '{2'd0, 32'd6, 1'b1, 32'd6, 32'd4};
    tbl[8] = '{2'd2, 32'd0, 1'b1, 32'd6, 32'd4};
    tbl[9] = '{2'd3, 32'd0, 1'b0, 32'd0, 32'd0};

    // Reset
    #2 resetn = 1'b0;
    cyc(3);
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    resetn = 1'b1;
    m_reset();
    cyc(2);

    // Reset-state poll of slots 1..12
    for (int i = 0; i < 12; i++) show(i + 1, rst_tbl[i]);

    // Stub adder: In1=5 then In2=7, with write-latency check on HCNT
    load(2'd0, 32'd5);
    chk("in1_after_load", 64'(alu_in1), 64'd5);
    show(8, mk(8, 1'b1, "HCNT ", 32'd0));
    show(8, mk(8, 1'b1, "HCNT ", 32'd0));
    show(8, mk(8, 1'b1, "HCNT ", 32'd1));
    load(2'd1, 32'd7);
    cyc(3);
    for (int n = 1; n <= 12; n++) show_m(n);

    // Table-driven loads: history fill, wrap, equal-value reload, clear
    for (int i = 0; i < 10; i++) begin
      load(tbl[i].sel, tbl[i].value);
      cyc(3);
      show(9, mk(9, tbl[i].h0_v, tbl[i].h0_v ? 40'("HIST0") : 40'd0, tbl[i].h0));
      show(8, mk(8, 1'b1, "HCNT ", tbl[i].hcnt));
      for (int n = 10; n <= 12; n++) show_m(n);
    end

    // Clear in the same cycle as a pending capture: clear wins
    load(2'd0, 32'd9);
    cyc(1);
    load(2'd3, 32'd0);
    cyc(3);
    show_m(8);
    show_m(9);

    // Auto-step: op 6 -> 7 -> 0, manual load of 3 on a tick, then 4
    load(2'd2, 32'd6);
    cyc(3);
    chk("op_loaded", 64'(alu_op), 64'(m_op));
    sw_auto = 1'b1;
    wait_op_change(20, c);
    m_op = m_op + OP_W'(1); m_auto = 1'b1; m_capture();
    chk("first_step_delay", 64'(c), 64'(STEP_DIV + 2));
    chk("step_to_7", 64'(alu_op), 64'(m_op));
    chk("led_auto_on", 64'(led_auto), 64'(m_auto));
    wait_op_change(20, c);
    m_op = m_op + OP_W'(1); m_capture();
    chk("step_gap_wrap", 64'(c), 64'(STEP_DIV));
    chk("step_wrap_0", 64'(alu_op), 64'(m_op));
    cyc(STEP_DIV - 1);
    load(2'd2, 32'd3);
    chk("load_on_tick", 64'(alu_op), 64'(m_op));
    wait_op_change(20, c);
    m_op = m_op + OP_W'(1); m_capture();
    chk("step_gap_after_load", 64'(c), 64'(STEP_DIV));
    chk("step_after_load", 64'(alu_op), 64'(m_op));
    sw_auto = 1'b0;
    cyc(STEP_DIV);
    m_auto = 1'b0;
    chk("led_auto_off", 64'(led_auto), 64'(m_auto));
    chk("op_held", 64'(alu_op), 64'(m_op));
    for (int n = 1; n <= 12; n++) show_m(n);

    // Carry-in toggle: synchroniser latency and one history capture
    sw_cin = 1'b1;
    c = 0;
    do begin @(posedge clk); #1; c++; end while (alu_ci !== 1'b1 && c < 6);
    chk("ci_latency_ok", 64'(c >= 2 && c <= 3), 64'd1);
    e_old = exp_slot(9);
    show(9, e_old);
    show(9, e_old);
    m_ci = 1'b1;
    m_capture();
    show_m(9);
    show_m(4);
    show_m(8);

    // led_cout follows alu_co one cycle later
    prev_co = m_sum() >> WIDTH;
    load(2'd1, 32'h0000_FFFF);
    chk("alu_co_set", 64'(alu_co), 64'(m_sum() >> WIDTH));
    chk("led_cout_lag_old", 64'(led_cout), 64'(prev_co));
    cyc(1);
    chk("led_cout_new", 64'(led_cout), 64'(m_sum() >> WIDTH));
    prev_co = m_sum() >> WIDTH;
    load(2'd1, 32'd0);
    chk("led_cout_lag_hold", 64'(led_cout), 64'(prev_co));
    cyc(1);
    chk("led_cout_clear", 64'(led_cout), 64'(m_sum() >> WIDTH));
    cyc(3);
    for (int n = 1; n <= 12; n++) show_m(n);

    // Asynchronous reset mid auto-run with a full history
    sw_auto = 1'b1;
    cyc(7 + $urandom_range(0, 3));
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    sw_auto = 1'b0;
    sw_cin = 1'b0;
    cyc(2);
    resetn = 1'b1;
    m_reset();
    cyc(3);
    for (int n = 1; n <= 12; n++) show_m(n);

    cyc(2);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_display_ctrl.md
# alu_display_ctrl

Parametrised operand/opcode controller and touch-screen display mapper for the ALU bring-up board. It sits between `lcd_module` and an external ALU instance. It loads operands and an opcode from touch-screen input, can auto-step the opcode on a timer, and keeps a circular history of recent ALU results. All state and the history are mapped onto the LCD display slots.

## Interface
Parameters:
- WIDTH, 32, ALU operand/result width; legal range 1..32.
- OP_W, 3, opcode width; legal range 1..5.
- HIST_DEPTH, 4, number of result-history entries; legal range 1..8.
- STEP_DIV, 10_000_000, clk cycles per auto-step (1 s at 10 MHz); must be ≥2.

Ports. Clock and reset: one clock `clk`; reset `resetn` is asynchronous and active-low.
- clk  in  1  system clock, 10 MHz
- resetn  in  1  asynchronous active-low reset
- input_sel  in  2  touch-input target: 0 In1, 1 In2, 2 opcode, 3 clear history
- sw_cin  in  1  carry-in switch, asynchronous to clk
- sw_auto  in  1  auto-step enable switch, asynchronous to clk
- input_valid  in  1  one-cycle strobe from lcd_module
- input_value  in  32  value accompanying input_valid
- display_number  in  6  slot currently requested by lcd_module
- display_valid  out  1  slot has content
- display_name  out  40  5-char ASCII slot name, space-padded on the right
- display_value  out  32  slot value, zero-extended
- alu_in1, alu_in2  out  WIDTH  ALU operands
- alu_op  out  OP_W  ALU opcode
- alu_ci  out  1  ALU carry-in
- alu_out  in  WIDTH  ALU result, combinational from alu_in*/alu_op/alu_ci
- alu_co  in  1  ALU carry-out
- led_cout  out  1  registered copy of alu_co
- led_auto  out  1  auto mode active

## Operation
- Reset values:
  - In1, In2, op are 0.
  - alu_ci, led_cout, led_auto are 0.
  - Step counter is 0. History pointer, count and all entries are 0.
  - display_valid is 0; display_name and display_value are 0.
  - Synchroniser flops are 0.
- sw_cin and sw_auto each pass through a 2-flop synchroniser. alu_ci and led_auto are the synchronised values.
- Loads on input_valid:
  - sel 0: In1 ← input_value[WIDTH-1:0].
  - sel 1: In2 ← input_value[WIDTH-1:0].
  - sel 2: op ← input_value[OP_W-1:0].
  - sel 3: clear history. Pointer = 0, count = 0; entries are not erased.
- Auto mode (led_auto=1):
  - The counter runs 0..STEP_DIV-1. At the terminal count it wraps to 0 and op ← op+1 mod 2^OP_W.
  - When led_auto=0 the counter is held at 0.
  - A manual opcode load (sel 2) in the same cycle as a tick wins: op takes the loaded value and the counter resets to 0.
- Change detect: `chg` is a 1-cycle flag, set one cycle after any of the following:
  - an In1, In2 or op register update, including an auto-step;
  - a toggle of alu_ci.
  - A load whose value equals the current value still counts as a change.
- Capture: when chg=1:
  - hist[ptr] ← alu_out; ptr ← ptr+1 mod HIST_DEPTH; count ← min(count+1, HIST_DEPTH).
  - If a clear and chg occur in the same cycle, the clear wins and no write happens.
- Display map, registered from display_number:
  - 1 "Oper1" In1; 2 "Oper2" In2; 3 "OP" op; 4 "CI" alu_ci; 5 "Out" alu_out; 6 "CO" alu_co; 7 "AUTO" led_auto; 8 "HCNT" count.
  - Slots 9..8+HIST_DEPTH are named "HIST0".."HIST7". HISTk shows the k-th newest entry, hist[(ptr-1-k) mod HIST_DEPTH].
  - HISTk has display_valid=1 only if k < count; otherwise valid=0, name 0, value 0.
  - All other slots: valid=0, name 0, value 0.

## Timing
- input_valid sampled at edge t → alu_in1/alu_in2/alu_op are updated after edge t. chg=1 during cycle t+1. History is written at edge t+2.
- sw_cin transition → alu_ci changes 2–3 edges later. The history write follows 2 edges after that.
- Auto-step: op changes every STEP_DIV cycles exactly while sw_auto is held. The first step comes STEP_DIV cycles after led_auto rises.
- display outputs lag display_number by exactly 1 cycle.
- led_cout lags alu_co by 1 cycle.
- Reset asserted mid-operation → all state returns to reset values immediately (asynchronously). Deassertion is synchronous to clk.
- Pointer wrap: after HIST_DEPTH+1 captures, the oldest entry is overwritten and count stays at HIST_DEPTH.

## Test plan
- Reset, then poll slots 1–12 → every slot reads 0; only slots 1–8 have valid=1; HIST slots have valid=0.
- With a stub ALU = add: load In1=5, then In2=7 with op=0 → HIST0=12, HIST1=5, HCNT=2. Each write lands 2 cycles after its input_valid.
- HIST_DEPTH=4; perform 6 loads giving results 1..6 → HCNT=4, HIST0..3 = 6,5,4,3. Then sel 3 → HCNT=0 and slots 9–12 have valid=0.
- STEP_DIV=4, OP_W=3, op=6, sw_auto=1 → op goes 7, then 0 (wrap), spaced 4 cycles apart. A sel 2 load of 3 on a tick cycle → op=3 and the next step comes 4 cycles later.
- Toggle sw_cin → alu_ci follows within 3 cycles. One history entry is added. led_cout tracks alu_co with a 1-cycle lag.
- Assert resetn low mid auto-run while the history is full → all outputs drop to reset values without a clock edge. After release, HCNT=0.
